// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared states, RTC register map and defaults for the RTC time write controller
package rtc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SET,
    S_A_WR,
    S_A_HOLD,
    S_D_SET,
    S_D_WR,
    S_D_HOLD,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HOR  = 8'h23;
  localparam logic [7:0] ADDR_XFER = 8'hF1;

  localparam int         T_PH_DEFAULT = 8;
  localparam logic [1:0] LAST_WRITE   = 2'd3;

  function automatic logic [7:0] addr_of(input logic [1:0] idx);
    case (idx)
      2'd0:    addr_of = ADDR_SEG;
      2'd1:    addr_of = ADDR_MIN;
      2'd2:    addr_of = ADDR_HOR;
      default: addr_of = ADDR_XFER;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - 8-bit down counter that times one bus phase of T_PH cycles
module phase_timer #(
  parameter int T_PH = rtc_pkg::T_PH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] RELOAD = 8'(T_PH - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Load wins over counting so a phase always starts from a full reload.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_write_ctrl.sv
// rtl/rtc_write_ctrl.sv - writes a snapshot of sec/min/hour plus a transfer command into an RTC over a muxed bus
module rtc_write_ctrl
  import rtc_pkg::*;
#(
  parameter int T_PH = T_PH_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       START,
  input  logic [7:0] SEG,
  input  logic [7:0] MIN,
  input  logic [7:0] HOR,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A_D,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       BUSY,
  output logic       DONE
);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hor_q, hor_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       ph_load;
  logic       ph_en;
  logic       ph_expire;
  logic [7:0] data_sel;

  assign ph_en   = (state_q != S_IDLE) && (state_q != S_FIN);
  assign ph_load = (state_d != state_q);

  phase_timer #(.T_PH(T_PH)) u_phase_timer (
    .clk    (CLK),
    .rst_n  (RESET_n),
    .load   (ph_load),
    .en     (ph_en),
    .expire (ph_expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    min_d   = min_q;
    hor_d   = hor_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_A_SET;
          idx_d   = 2'd0;
          seg_d   = SEG;
          min_d   = MIN;
          hor_d   = HOR;
        end
      end
      S_FIN:    state_d = S_IDLE;
      S_A_SET:  if (ph_expire) state_d = S_A_WR;
      S_A_WR:   if (ph_expire) state_d = S_A_HOLD;
      S_A_HOLD: if (ph_expire) state_d = S_D_SET;
      S_D_SET:  if (ph_expire) state_d = S_D_WR;
      S_D_WR:   if (ph_expire) state_d = S_D_HOLD;
      S_D_HOLD: if (ph_expire) state_d = S_GAP;
      S_GAP: begin
        if (ph_expire) begin
          if (idx_q == LAST_WRITE) begin
            state_d = S_FIN;
          end else begin
            state_d = S_A_SET;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (idx_d)
      2'd0:    data_sel = seg_d;
      2'd1:    data_sel = min_d;
      2'd2:    data_sel = hor_d;
      default: data_sel = 8'h00;
    endcase
  end

  // Bus outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b0;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    case (state_d)
      S_A_SET, S_A_WR, S_A_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_of(idx_d);
        wr_n_d   = (state_d != S_A_WR);
      end
      S_D_SET, S_D_WR, S_D_HOLD: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = data_sel;
        wr_n_d   = (state_d != S_D_WR);
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      seg_q    <= 8'h00;
      min_q    <= 8'h00;
      hor_q    <= 8'h00;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_d_q    <= 1'b0;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      min_q    <= min_d;
      hor_q    <= hor_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      a_d_q    <= a_d_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign CS_n   = cs_n_q;
  assign RD_n   = 1'b1;
  assign WR_n   = wr_n_q;
  assign A_D    = a_d_q;
  assign AD_out = ad_out_q;
  assign AD_oe  = ad_oe_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_rtc_write_ctrl.sv
// tb/tb_rtc_write_ctrl.sv - directed bench for rtc_write_ctrl at T_PH=2 and T_PH=1
module tb_rtc_write_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  logic       rst2, start2, cs2, rd2, wr2, a_d2, oe2, busy2, done2;
  logic [7:0] seg2, min2, hor2, adout2;
  logic       rst1, start1, cs1, rd1, wr1, a_d1, oe1, busy1, done1;
  logic [7:0] seg1, min1, hor1, adout1;

  rtc_write_ctrl #(.T_PH(2)) dut2 (
    .CLK(clk), .RESET_n(rst2), .START(start2), .SEG(seg2), .MIN(min2), .HOR(hor2),
    .CS_n(cs2), .RD_n(rd2), .WR_n(wr2), .A_D(a_d2), .AD_out(adout2), .AD_oe(oe2),
    .BUSY(busy2), .DONE(done2)
  );

  rtc_write_ctrl #(.T_PH(1)) dut1 (
    .CLK(clk), .RESET_n(rst1), .START(start1), .SEG(seg1), .MIN(min1), .HOR(hor1),
    .CS_n(cs1), .RD_n(rd1), .WR_n(wr1), .A_D(a_d1), .AD_out(adout1), .AD_oe(oe1),
    .BUSY(busy1), .DONE(done1)
  );

  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  int         pulse_len[$];
  int         done2_cnt = 0;
  logic       prev_wr2 = 1'b1;
  int         wr_len2 = 0;
  logic [7:0] cur_addr2 = 8'h00;
  logic [7:0] cur_data2 = 8'h00;
  logic       cur_is_data2 = 1'b0;

  always @(negedge clk) begin
    if (done2) done2_cnt++;
    if (!wr2) begin
      wr_len2++;
      cur_is_data2 = a_d2;
      if (a_d2) cur_data2 = adout2;
      else      cur_addr2 = adout2;
    end else if (!prev_wr2) begin
      pulse_len.push_back(wr_len2);
      if (cur_is_data2) begin
        log_addr.push_back(cur_addr2);
        log_data.push_back(cur_data2);
      end
      wr_len2 = 0;
    end
    prev_wr2 = wr2;
  end

  logic       prev_cs1 = 1'b1;
  logic       prev_wr1 = 1'b1;
  logic       prev_ad1 = 1'b0;
  logic [7:0] prev_out1 = 8'h00;
  int         viol1 = 0;
  int         writes1 = 0;
  int         done1_cnt = 0;

  always @(negedge clk) begin
    if (done1) done1_cnt++;
    if (!cs1 && !prev_cs1 && (wr1 != prev_wr1) && ((a_d1 != prev_ad1) || (adout1 != prev_out1)))
      viol1++;
    if (!wr1 && a_d1) writes1++;
    prev_cs1  = cs1;
    prev_wr1  = wr1;
    prev_ad1  = a_d1;
    prev_out1 = adout1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_addr[4];
  logic [7:0] exp_data[4];
  int         n;
  int         sz;
  int         low_cnt;

  initial begin
    exp_addr = '{8'h21, 8'h22, 8'h23, 8'hF1};
    exp_data = '{8'h45, 8'h30, 8'h12, 8'h00};
    rst2 = 1'b0; start2 = 1'b0; seg2 = 8'h45; min2 = 8'h30; hor2 = 8'h12;
    rst1 = 1'b0; start1 = 1'b0; seg1 = 8'h07; min1 = 8'h59; hor1 = 8'h23;
    repeat (2) tick;

    chk("rst_cs_n", cs2, 1'b1);
    chk("rst_rd_n", rd2, 1'b1);
    chk("rst_wr_n", wr2, 1'b1);
    chk("rst_a_d", a_d2, 1'b0);
    chk("rst_ad_oe", oe2, 1'b0);
    chk("rst_ad_out", adout2, 8'h00);
    chk("rst_busy", busy2, 1'b0);
    chk("rst_done", done2, 1'b0);

    rst2 = 1'b1; rst1 = 1'b1;
    tick;
    chk("idle_busy", busy2, 1'b0);

    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    seg2 = 8'h59;
    chk("aset_busy", busy2, 1'b1);
    chk("aset_cs_n", cs2, 1'b0);
    chk("aset_a_d", a_d2, 1'b0);
    chk("aset_ad_out", adout2, 8'h21);
    chk("aset_wr_n", wr2, 1'b1);
    chk("aset_ad_oe", oe2, 1'b1);
    chk("aset_rd_n", rd2, 1'b1);

    n = 0;
    while (!done2 && n < 200) begin
      start2 = (n == 10);
      tick;
      n++;
    end
    start2 = 1'b0;
    chk("done_latency", n, 56);
    chk("fin_busy", busy2, 1'b1);
    chk("fin_cs_n", cs2, 1'b1);
    chk("fin_ad_oe", oe2, 1'b0);

    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("fin_start_ignored_busy", busy2, 1'b0);
    chk("idle_done", done2, 1'b0);
    chk("idle_cs_n", cs2, 1'b1);
    chk("idle_ad_out", adout2, 8'h00);
    repeat (5) tick;

    chk("log_count", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("log_addr", log_addr[i], exp_addr[i]);
      chk("log_data", log_data[i], exp_data[i]);
    end
    chk("strobe_count", pulse_len.size(), 8);
    for (int i = 0; i < pulse_len.size(); i++) begin
      chk("strobe_len", pulse_len[i], 2);
    end
    chk("done_count", done2_cnt, 1);

    seg2 = 8'h45;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    n = 0;
    while (!(wr2 == 1'b0 && a_d2 == 1'b1 && adout2 == 8'h30) && n < 500) begin
      tick;
      n++;
    end
    chk("abort_reached_dwr2", (n < 500), 1'b1);
    #1 rst2 = 1'b0;
    #1;
    chk("abort_cs_n", cs2, 1'b1);
    chk("abort_wr_n", wr2, 1'b1);
    chk("abort_ad_oe", oe2, 1'b0);
    chk("abort_busy", busy2, 1'b0);
    tick;
    rst2 = 1'b1;
    sz = log_addr.size();
    low_cnt = 0;
    repeat (100) begin
      tick;
      if (!cs2) low_cnt++;
    end
    chk("post_abort_cs_quiet", low_cnt, 0);
    chk("post_abort_no_writes", log_addr.size(), sz);
    chk("post_abort_busy", busy2, 1'b0);

    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      tick;
    end
    chk("t1_busy_len_a", n, 29);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("t1_restart_accepted", busy1, 1'b1);
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      tick;
    end
    chk("t1_busy_len_b", n, 29);
    repeat (3) tick;
    chk("t1_data_strobes", writes1, 8);
    chk("t1_strobe_stability", viol1, 0);
    chk("t1_done_count", done1_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
